// File: rtl/pc_fetch_btb.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Handles stall, resolved-branch redirect and BTB training from branch resolution.
module pc_fetch_btb #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            pc_valid_q;

  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [IDX-1:0]   up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  // Low address bits never reach the BTB or the aligned redirect target.
  logic unused_lsbs;
  assign unused_lsbs = ^{update_pc[1:0], redirect_pc[1:0]};

  assign rd_idx = pc_q[IDX+1:2];
  assign rd_tag = pc_q[XLEN-1:IDX+2];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign up_idx = update_pc[IDX+1:2];
  assign up_tag = update_pc[XLEN-1:IDX+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Prediction reads pre-edge BTB contents; a same-cycle update shows up next cycle.
  always_comb begin
    pred_taken  = rd_hit && ctr_q[rd_idx][1];
    pred_target = pc_q + XLEN'(4);
    if (pred_taken) begin
      pred_target = target_q[rd_idx];
    end
  end

  // Next-PC priority: redirect, then stall, then prediction.
  always_comb begin
    pc_d = pred_target;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
    end
  end

  // BTB training; a miss that resolves not-taken never allocates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (update_valid) begin
      if (up_hit) begin
        if (update_taken) begin
          if (ctr_q[up_idx] != 2'b11) begin
            ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
          end
          target_q[up_idx] <= update_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
        end
      end else if (update_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  assign pc_out   = pc_q;
  assign pc_valid = pc_valid_q;

endmodule

// File: tb/tb_pc_fetch_btb.sv
// Directed bench for pc_fetch_btb: expected outputs are queued as stimulus is
// driven and checked one cycle later (or immediately for combinational checks).
module tb_pc_fetch_btb;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        update_valid;
  logic [63:0] update_pc;
  logic [63:0] update_target;
  logic        update_taken;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic        pred_taken;
  logic [63:0] pred_target;

  typedef struct {
    logic [63:0] pc;
    logic        valid;
    logic        ptaken;
    logic [63:0] ptarget;
  } exp_t;

  exp_t sb[$];
  int vectors;
  int miscompares;

  pc_fetch_btb #(.XLEN(64), .BTB_ENTRIES(16), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_target  (update_target),
    .update_taken   (update_taken),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic v, input logic pt, input logic [63:0] ptgt);
    exp_t e;
    e.pc = pc; e.valid = v; e.ptaken = pt; e.ptarget = ptgt;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc_out"},      pc_out,             e.pc);
      chk({tag, ".pc_valid"},    64'(pc_valid),      64'(e.valid));
      chk({tag, ".pred_taken"},  64'(pred_taken),    64'(e.ptaken));
      chk({tag, ".pred_target"}, pred_target,        e.ptarget);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic drive(input logic st, input logic rv, input logic [63:0] rpc,
                       input logic uv, input logic [63:0] upc, input logic [63:0] utgt,
                       input logic ut);
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    update_valid = uv; update_pc = upc; update_target = utgt; update_taken = ut;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    drive(0, 0, 64'h0, 0, 64'h0, 64'h0, 0);

    // Reset and sequential fetch
    repeat (3) @(posedge clk);
    #1;
    push(64'h0, 0, 0, 64'h4); compare("in_reset");
    reset = 1'b1;
    #1;
    push(64'h0, 0, 0, 64'h4); compare("post_release");
    push(64'h4,  1, 0, 64'h8);  tick("seq4");
    push(64'h8,  1, 0, 64'hC);  tick("seq8");
    push(64'hC,  1, 0, 64'h10); tick("seqC");
    push(64'h10, 1, 0, 64'h14); tick("seq10");

    // Stall, then redirect overriding stall
    drive(1, 0, 64'h0, 0, 64'h0, 64'h0, 0);
    push(64'h10, 1, 0, 64'h14); tick("stall1");
    push(64'h10, 1, 0, 64'h14); tick("stall2");
    drive(1, 1, 64'h203, 0, 64'h0, 64'h0, 0);
    push(64'h200, 1, 0, 64'h204); tick("redir_over_stall");

    // Allocate on taken miss, then predict
    drive(0, 0, 64'h0, 1, 64'h40, 64'h100, 1);
    push(64'h204, 1, 0, 64'h208); tick("alloc");
    drive(0, 1, 64'h40, 0, 64'h0, 64'h0, 0);
    push(64'h40, 1, 1, 64'h100); tick("predict40");
    drive(0, 0, 64'h0, 0, 64'h0, 64'h0, 0);
    push(64'h100, 1, 0, 64'h104); tick("follow_pred");

    // Saturation: three taken then one not-taken while stalled at 0x100
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 64'h0, 1, 64'h40, 64'h100, 1);
      push(64'h100, 1, 0, 64'h104); tick("sat_taken");
    end
    drive(1, 0, 64'h0, 1, 64'h40, 64'h100, 0);
    push(64'h100, 1, 0, 64'h104); tick("nt1");
    drive(0, 1, 64'h40, 0, 64'h0, 64'h0, 0);
    push(64'h40, 1, 1, 64'h100); tick("hysteresis");
    drive(1, 0, 64'h0, 1, 64'h40, 64'h100, 0);
    push(64'h40, 1, 0, 64'h44); tick("nt2");

    // Collision: training the current PC's entry uses the old prediction
    drive(0, 0, 64'h0, 1, 64'h40, 64'h300, 1);
    #1;
    push(64'h40, 1, 0, 64'h44); compare("collide_pre");
    push(64'h44, 1, 0, 64'h48); tick("collide_next");
    drive(0, 1, 64'h40, 0, 64'h0, 64'h0, 0);
    push(64'h40, 1, 1, 64'h300); tick("collide_new");

    // Alias replacement and no allocation on not-taken miss
    drive(1, 0, 64'h0, 1, 64'h440, 64'h500, 1);
    push(64'h40, 1, 0, 64'h44); tick("alias_evict");
    drive(0, 0, 64'h0, 1, 64'h80, 64'h900, 0);
    push(64'h44, 1, 0, 64'h48); tick("noalloc");
    drive(0, 1, 64'h80, 0, 64'h0, 64'h0, 0);
    push(64'h80, 1, 0, 64'h84); tick("miss80");
    drive(0, 1, 64'h440, 0, 64'h0, 64'h0, 0);
    push(64'h440, 1, 1, 64'h500); tick("hit440");

    // Wrap-around of PC+4
    drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 64'h0, 0);
    push(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h0); tick("wrap_pc");
    drive(0, 0, 64'h0, 0, 64'h0, 64'h0, 0);
    push(64'h0, 1, 0, 64'h4); tick("wrap_zero");

    // Asynchronous reset mid-cycle clears PC, valid and BTB
    drive(0, 0, 64'h0, 1, 64'h440, 64'h700, 1);
    #2;
    reset = 1'b0;
    #1;
    push(64'h0, 0, 0, 64'h4); compare("async_reset");
    tick_hold: begin
      push(64'h0, 0, 0, 64'h4); tick("reset_held");
    end
    drive(0, 0, 64'h0, 0, 64'h0, 64'h0, 0);
    reset = 1'b1;
    push(64'h4, 1, 0, 64'h8); tick("reset_resume");
    drive(0, 1, 64'h440, 0, 64'h0, 64'h0, 0);
    push(64'h440, 1, 0, 64'h444); tick("btb_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
